// File: rtl/cpu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_seq : multi-cycle instruction sequencer FETCH/DECODE/EXEC/MEM/WB  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module cpu_seq #(
  parameter int                 XLEN     = 32,
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] pc,
  output logic              decode_en,
  output logic              exec_en,
  output logic              wb_en,
  input  logic              stall,
  input  logic              is_mem,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [XLEN-1:0]   ls_wdata,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] next_pc,
  output logic [XLEN-1:0]   ld_data,
  output logic              bus_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [XLEN-1:0]   ld_q, ld_d;
  logic [7:0]        wait_q, wait_d;
  logic              is_mem_q, is_mem_d;
  logic              we_q, we_d;
  logic              pc_load_q, pc_load_d;
  logic [ADDR_W-1:0] npc_q, npc_d;
  logic [ADDR_W-1:0] pc_wb;
  logic              timeout;

  assign pc_wb   = pc_load_q ? npc_q : pc_q + ADDR_W'(4);
  assign timeout = !mem_ready && (wait_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      ld_q      <= '0;
      wait_q    <= '0;
      is_mem_q  <= 1'b0;
      we_q      <= 1'b0;
      pc_load_q <= 1'b0;
      npc_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      ld_q      <= ld_d;
      wait_q    <= wait_d;
      is_mem_q  <= is_mem_d;
      we_q      <= we_d;
      pc_load_q <= pc_load_d;
      npc_q     <= npc_d;
    end
  end

  // wait_d defaults to zero so the counter is clear on every entry to FETCH/MEM
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    ld_d      = ld_q;
    wait_d    = '0;
    is_mem_d  = is_mem_q;
    we_d      = we_q;
    pc_load_d = pc_load_q;
    npc_d     = npc_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    decode_en = 1'b0;
    exec_en   = 1'b0;
    wb_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = (pc_q[1:0] != 2'b00) ? S_ERROR : S_FETCH;
      end
      S_FETCH: begin
        mem_ren  = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          ir_d    = mem_rdata[31:0];
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        decode_en = 1'b1;
        if (!stall) state_d = S_EXEC;
      end
      S_EXEC: begin
        exec_en   = 1'b1;
        is_mem_d  = is_mem;
        we_d      = mem_we;
        pc_load_d = pc_load;
        npc_d     = next_pc;
        state_d   = is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_addr  = ls_addr;
        mem_wdata = ls_wdata;
        mem_wen   = we_q;
        mem_ren   = !we_q;
        if (mem_ready) begin
          if (!we_q) ld_d = mem_rdata;
          state_d = S_WB;
        end else if (timeout) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        wb_en   = 1'b1;
        pc_d    = pc_wb;
        // a misaligned target never reaches FETCH, so no read is issued
        state_d = (pc_wb[1:0] != 2'b00) ? S_ERROR : S_FETCH;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ir      = ir_q;
  assign pc      = pc_q;
  assign ld_data = ld_q;
  assign bus_err = (state_q == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_cpu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cpu_seq : randomized self-checking bench for cpu_seq               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_cpu_seq;
  localparam int          XLEN     = 32;
  localparam int          ADDR_W   = 32;
  localparam int          TIMEOUT  = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [XLEN-1:0]   mem_rdata = '0;
  logic              mem_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ren, mem_wen;
  logic [31:0]       ir;
  logic [ADDR_W-1:0] pc;
  logic              decode_en, exec_en, wb_en;
  logic              stall = 1'b0;
  logic              is_mem = 1'b0, mem_we = 1'b0;
  logic [ADDR_W-1:0] ls_addr = '0;
  logic [XLEN-1:0]   ls_wdata = '0;
  logic              pc_load = 1'b0;
  logic [ADDR_W-1:0] next_pc = '0;
  logic [XLEN-1:0]   ld_data;
  logic              bus_err;

  cpu_seq #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .ir(ir), .pc(pc), .decode_en(decode_en), .exec_en(exec_en), .wb_en(wb_en),
    .stall(stall), .is_mem(is_mem), .mem_we(mem_we), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .pc_load(pc_load), .next_pc(next_pc),
    .ld_data(ld_data), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Architectural model: expected pc, ir and ld_data between instructions
  logic [31:0] m_pc, m_ir, m_ld;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [4:0] exp);
    chk(tag, {mem_ren, mem_wen, decode_en, exec_en, wb_en}, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_outs("rst_outs", 5'b00000);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_ir", ir, 0);
    chk("rst_ld", ld_data, 0);
    chk("rst_err", bus_err, 0);
    m_pc = RESET_PC; m_ir = '0; m_ld = '0;
    rst_n = 1'b1;
    @(negedge clk);
    chk_outs("idle_outs", 5'b00000);
    @(posedge clk); #1;
  endtask

  task automatic chk_error(input int n, input logic [31:0] exp_pc);
    for (int c = 0; c < n; c++) begin
      mem_ready = 1'($urandom);
      mem_rdata = $urandom;
      stall = 1'($urandom);
      @(negedge clk);
      chk("err_flag", bus_err, 1);
      chk_outs("err_outs", 5'b00000);
      chk("err_wdata", mem_wdata, 0);
      chk("err_pc", pc, exp_pc);
      @(posedge clk); #1;
    end
    stall = 1'b0;
  endtask

  // One instruction, phase by phase. Waits >= TIMEOUT mean "never ready".
  task automatic do_instr(input int wf, input logic [31:0] instr, input int s,
                          input bit im, input bit we, input bit pl,
                          input logic [31:0] npc, input logic [31:0] la,
                          input logic [31:0] wd, input int wm,
                          input logic [31:0] rdv, input int rst_at,
                          output bit aborted);
    int unsigned t0;
    int lastf, lastm;
    aborted = 1'b0;
    t0 = 0;
    lastf = (wf >= TIMEOUT) ? TIMEOUT - 1 : wf;
    lastm = (wm >= TIMEOUT) ? TIMEOUT - 1 : wm;
    for (int c = 0; c <= lastf; c++) begin
      mem_ready = (c == wf);
      mem_rdata = (c == wf) ? instr : $urandom;
      @(negedge clk);
      if (c == 0) t0 = cyc;
      chk_outs("fetch_outs", 5'b10000);
      chk("fetch_addr", mem_addr, m_pc);
      chk("fetch_wdata", mem_wdata, 0);
      @(posedge clk); #1;
    end
    if (wf >= TIMEOUT) begin
      aborted = 1'b1;
      return;
    end
    m_ir = instr;
    for (int c = 0; c <= s; c++) begin
      stall = (c < s);
      mem_ready = 1'($urandom);
      mem_rdata = $urandom;
      @(negedge clk);
      chk_outs("dec_outs", 5'b00100);
      chk("ir", ir, m_ir);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    is_mem = im; mem_we = we; pc_load = pl; next_pc = npc;
    ls_addr = la; ls_wdata = wd;
    mem_ready = 1'($urandom);
    @(negedge clk);
    chk_outs("exec_outs", 5'b00010);
    @(posedge clk); #1;
    is_mem = 1'($urandom); mem_we = 1'($urandom);
    pc_load = 1'($urandom); next_pc = $urandom;
    if (im) begin
      for (int c = 0; c <= lastm; c++) begin
        mem_ready = (c == wm);
        mem_rdata = (c == wm) ? rdv : $urandom;
        @(negedge clk);
        chk_outs("mem_outs", {!we, we, 3'b000});
        chk("mem_addr", mem_addr, la);
        chk("mem_wdata", mem_wdata, wd);
        if (c == rst_at) begin
          #2 rst_n = 1'b0;
          #1;
          chk_outs("async_rst_outs", 5'b00000);
          chk("async_rst_err", bus_err, 0);
          chk("async_rst_pc", pc, RESET_PC);
          m_pc = RESET_PC; m_ir = '0; m_ld = '0;
          aborted = 1'b1;
          return;
        end
        if (c == wm && !we) m_ld = rdv;
        @(posedge clk); #1;
      end
      if (wm >= TIMEOUT) begin
        aborted = 1'b1;
        return;
      end
    end
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
    @(negedge clk);
    chk_outs("wb_outs", 5'b00001);
    chk("wb_wdata", mem_wdata, 0);
    chk("ld_data", ld_data, m_ld);
    chk("latency", cyc - t0, wf + s + 3 + (im ? wm + 1 : 0));
    m_pc = pl ? npc : m_pc + 32'd4;
    @(posedge clk); #1;
    chk("pc_next", pc, m_pc);
  endtask

  initial begin
    bit ab;
    do_reset();
    // back-to-back zero-wait NOPs from address 0
    repeat (3) do_instr(0, 32'h13, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, ab);
    // load, 3 wait states
    do_instr(0, 32'h0000_0103, 0, 1, 0, 0, 0, 32'h100, 0, 3, 32'hDEAD_BEEF, -1, ab);
    // stall 5 cycles in DECODE
    do_instr(0, 32'h13, 5, 0, 0, 0, 0, 0, 0, 0, 0, -1, ab);
    // ready on the last allowed fetch wait cycle wins over timeout
    do_instr(TIMEOUT - 1, 32'h13, 0, 1, 1, 0, 0, 32'h200, 32'h1234_5678, TIMEOUT - 1, 0, -1, ab);
    // branch then fetch from target; wrap at top of address space
    do_instr(0, 32'h6F, 0, 0, 0, 1, 32'h40, 0, 0, 0, 0, -1, ab);
    do_instr(0, 32'h6F, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, -1, ab);
    do_instr(0, 32'h13, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, ab);
    chk("wrap_pc", m_pc, pc);
    for (int i = 0; i < 150; i++) begin
      bit pl_r;
      pl_r = ($urandom_range(0, 3) == 0);
      do_instr($urandom_range(0, TIMEOUT - 1), $urandom, $urandom_range(0, 3),
               1'($urandom), 1'($urandom), pl_r, $urandom & 32'hFFFF_FFFC,
               $urandom, $urandom, $urandom_range(0, TIMEOUT - 1), $urandom, -1, ab);
    end
    // misaligned branch target
    do_instr(0, 32'h6F, 0, 0, 0, 1, 32'h42, 0, 0, 0, 0, -1, ab);
    chk_error(3, 32'h42);
    // fetch timeout
    do_reset();
    do_instr(TIMEOUT, 32'h13, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, ab);
    chk("fetch_to_abort", ab, 1);
    chk_error(3, RESET_PC);
    // memory-phase timeout
    do_reset();
    do_instr(0, 32'h13, 0, 1, 0, 0, 0, 32'h300, 0, TIMEOUT, 0, -1, ab);
    chk("mem_to_abort", ab, 1);
    chk_error(3, RESET_PC);
    // reset during a pending store
    do_reset();
    do_instr(0, 32'h13, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, ab);
    do_instr(0, 32'h23, 0, 1, 1, 0, 0, 32'h400, 32'hCAFE_F00D, 3, 0, 1, ab);
    chk("store_rst_abort", ab, 1);
    do_reset();
    do_instr(0, 32'h13, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, ab);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cpu_seq.md
CPU_SEQ -- requirements
Module: cpu_seq

Interface
REQ-001 Parameter XLEN, default 32, data-path width of the memory data buses and the load data.
REQ-002 Parameter ADDR_W, default 32, width of the PC and memory address.
REQ-003 Parameter RESET_PC, default 0, PC value after reset.
REQ-004 Parameter TIMEOUT, default 15 (range 1..255), maximum consecutive mem_ready-low wait cycles before a bus error.
REQ-005 Port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port mem_rdata, input, XLEN, memory read data, valid when mem_ready=1.
REQ-008 Port mem_ready, input, 1, memory completion strobe for the current access.
REQ-009 Port mem_addr, output, ADDR_W, memory address.
REQ-010 Port mem_wdata, output, XLEN, store data.
REQ-011 Port mem_ren, output, 1, read request.
REQ-012 Port mem_wen, output, 1, write request.
REQ-013 Port ir, output, 32, latched instruction.
REQ-014 Port pc, output, ADDR_W, address of the current instruction.
REQ-015 Port decode_en, exec_en and wb_en, outputs, 1 each, stage enables.
REQ-016 Port stall, input, 1, holds the sequencer in DECODE.
REQ-017 Port is_mem and mem_we, inputs, 1 each, sampled in EXEC; they mark a load (is_mem=1, mem_we=0) or a store (is_mem=1, mem_we=1).
REQ-018 Port ls_addr (ADDR_W) and ls_wdata (XLEN), inputs, load/store address and data, held stable by the executor through MEM.
REQ-019 Port pc_load (1) and next_pc (ADDR_W), inputs, branch/jump target, sampled in EXEC.
REQ-020 Port ld_data, output, XLEN, registered load result.
REQ-021 Port bus_err, output, 1, sticky error flag.

Function
REQ-022 The sequencer SHALL have the states IDLE, FETCH, DECODE, EXEC, MEM, WB and ERROR.
REQ-023 IDLE SHALL go to FETCH on the next clock unconditionally.
REQ-024 In FETCH the block SHALL drive mem_ren=1 and mem_addr=pc; on the first cycle with mem_ready=1 it SHALL latch ir<=mem_rdata[31:0] and go to DECODE.
REQ-025 In DECODE the block SHALL drive decode_en=1; it SHALL stay in DECODE while stall=1, else go to EXEC.
REQ-026 In EXEC the block SHALL drive exec_en=1 for exactly one cycle and register is_mem, mem_we, pc_load and next_pc; it SHALL go to MEM if is_mem=1, else to WB.
REQ-027 In MEM the block SHALL drive mem_addr=ls_addr, mem_wdata=ls_wdata, mem_wen=mem_we and mem_ren=!mem_we; on mem_ready=1 it SHALL latch ld_data<=mem_rdata (loads only) and go to WB.
REQ-028 In WB the block SHALL drive wb_en=1 for one cycle, update pc<=next_pc if pc_load was registered, else pc<=pc+4, and go to FETCH.
REQ-029 PC arithmetic SHALL be modulo 2^ADDR_W (wrap without error).
REQ-030 Instruction latency with zero wait states SHALL be 4 cycles (FETCH to WB) for a non-memory instruction and 5 cycles for a load or store.
REQ-031 A wait counter SHALL clear on entry to FETCH or MEM; if mem_ready stays low for TIMEOUT consecutive cycles, the next state SHALL be ERROR.
REQ-032 When mem_ready=1 arrives on the TIMEOUT-th wait cycle, completion SHALL take priority over the timeout.
REQ-033 Entering FETCH with pc[1:0]!=0 SHALL go directly to ERROR without asserting mem_ren.
REQ-034 In ERROR, bus_err SHALL be 1, all enables and memory requests SHALL be 0, and the state SHALL persist until reset.
REQ-035 mem_ready SHALL be ignored in any state other than FETCH and MEM.
REQ-036 mem_ren, mem_wen and the enables SHALL be decoded from the state only; they SHALL never be asserted together except mem_ren alone or mem_wen alone.
REQ-037 mem_wdata SHALL be 0 outside MEM.

Reset
REQ-038 rst_n=0 SHALL immediately force state=IDLE, pc=RESET_PC, ir=0, ld_data=0, bus_err=0, the wait counter to 0, and all request and enable outputs to 0.
REQ-039 Reset asserted mid-access SHALL abandon the access without completion; the first fetch after release SHALL be from RESET_PC.

Verification
REQ-040 Release reset, memory always ready with 0x00000013 at address 0 -> enables sequence FETCH,DECODE,EXEC,WB repeats; pc = 0,4,8 at 4-cycle intervals.
REQ-041 Load with ls_addr=0x100, mem_ready delayed 3 cycles, data 0xDEADBEEF -> mem_ren held 4 cycles in MEM; ld_data=0xDEADBEEF in WB; instruction takes 8 cycles.
REQ-042 Branch with pc_load=1, next_pc=0x40 in EXEC -> the next fetch has mem_addr=0x40; next_pc=0x42 -> ERROR and bus_err=1 with no mem_ren.
REQ-043 TIMEOUT=4 and mem_ready held low in FETCH -> ERROR after 4 wait cycles; the same test with ready on cycle 4 -> DECODE.
REQ-044 stall=1 for 5 cycles in DECODE -> decode_en held 5+1 cycles; exec_en pulses once.
REQ-045 Assert rst_n=0 during a pending MEM store -> mem_wen drops asynchronously; after release, fetch from RESET_PC with bus_err=0.
